// File: rtl/hazard_forward_unit_pkg.sv
// Shared pipeline definitions for the hazard/forwarding controller:
// register-address width, forward-source encodings and the in-flight
// hazard slot record.
package hazard_forward_unit_pkg;

  localparam int REG_ADDR_W = 5;

  // Forward source select seen by the EX operand muxes
  localparam logic FWD_SRC_ALU    = 1'b0;
  localparam logic FWD_SRC_RESULT = 1'b1;

  // Destination bookkeeping for one in-flight instruction
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  load;
  } hazSlot_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle between the ID stage and the hazard/forwarding controller.
// Optional macro HAZARD_PERF_EN adds the stallCount/flushCount counters.
interface hazard_forward_unit_if;
  import hazard_forward_unit_pkg::*;

  logic                  idValid;
  logic [REG_ADDR_W-1:0] rs1Id;
  logic [REG_ADDR_W-1:0] rs2Id;
  logic                  useRs1;
  logic                  useRs2;
  logic [REG_ADDR_W-1:0] rdId;
  logic                  regWriteId;
  logic                  memReadId;
  logic                  flush;
  logic                  stall;
  logic                  bubbleE;
  logic                  Fa;
  logic                  Fb;
  logic                  fwdSrcA;
  logic                  fwdSrcB;
`ifdef HAZARD_PERF_EN
  logic [31:0]           stallCount;
  logic [31:0]           flushCount;
`endif

  // ID-stage side: presents the decoded instruction, consumes controls
  modport master (
    output idValid, rs1Id, rs2Id, useRs1, useRs2, rdId, regWriteId,
           memReadId, flush,
    input  stall, bubbleE, Fa, Fb, fwdSrcA,
`ifdef HAZARD_PERF_EN
           stallCount, flushCount,
`endif
           fwdSrcB
  );

  // Controller side
  modport slave (
    input  idValid, rs1Id, rs2Id, useRs1, useRs2, rdId, regWriteId,
           memReadId, flush,
    output stall, bubbleE, Fa, Fb, fwdSrcA,
`ifdef HAZARD_PERF_EN
           stallCount, flushCount,
`endif
           fwdSrcB
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forward match: compares one ID source register against the
// EX and MEM producers and picks the younger (EX) one when both match.
module hazard_fwd_select
  import hazard_forward_unit_pkg::*;
(
  input  logic                  i_use,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_exRd,
  input  logic                  i_exWe,
  input  logic [REG_ADDR_W-1:0] i_memRd,
  input  logic                  i_memWe,
  output logic                  o_fwd,
  output logic                  o_src
);

  // Younger producer first; x0 is never forwarded
  always_comb begin
    o_fwd = 1'b0;
    o_src = FWD_SRC_ALU;
    if (i_use && (i_rs != '0)) begin
      if (i_exWe && (i_exRd == i_rs)) begin
        o_fwd = 1'b1;
        o_src = FWD_SRC_ALU;
      end else if (i_memWe && (i_memRd == i_rs)) begin
        o_fwd = 1'b1;
        o_src = FWD_SRC_RESULT;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline. Tracks the
// destinations of the instructions in EX and MEM, raises the load-use
// stall, requests ID/EX bubbles and registers the EX forward selects in
// step with the ID/EX register.
// Optional macro HAZARD_PERF_EN adds free-running stall/flush counters.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  hazard_forward_unit_if.slave  hazBus
);

  hazSlot_t              r_exSlot;
  logic [REG_ADDR_W-1:0] r_memRd;
  logic                  r_memWe;
  logic                  r_fa;
  logic                  r_fb;
  logic                  r_srcA;
  logic                  r_srcB;

  logic                  w_stall;
  logic                  w_bubble;
  logic                  w_rsHitEx;
  logic                  w_fwdA;
  logic                  w_fwdB;
  logic                  w_srcA;
  logic                  w_srcB;

  // Load-use detection against the load currently in EX; flush wins
  always_comb begin
    w_rsHitEx = (hazBus.useRs1 && (hazBus.rs1Id == r_exSlot.rd)) ||
                (hazBus.useRs2 && (hazBus.rs2Id == r_exSlot.rd));
    w_stall   = hazBus.idValid && !hazBus.flush && r_exSlot.load &&
                r_exSlot.we && (r_exSlot.rd != '0) && w_rsHitEx;
    w_bubble  = w_stall || hazBus.flush || !hazBus.idValid;
  end

  hazard_fwd_select u_selA (
    .i_use   (hazBus.useRs1),
    .i_rs    (hazBus.rs1Id),
    .i_exRd  (r_exSlot.rd),
    .i_exWe  (r_exSlot.we),
    .i_memRd (r_memRd),
    .i_memWe (r_memWe),
    .o_fwd   (w_fwdA),
    .o_src   (w_srcA)
  );

  hazard_fwd_select u_selB (
    .i_use   (hazBus.useRs2),
    .i_rs    (hazBus.rs2Id),
    .i_exRd  (r_exSlot.rd),
    .i_exWe  (r_exSlot.we),
    .i_memRd (r_memRd),
    .i_memWe (r_memWe),
    .o_fwd   (w_fwdB),
    .o_src   (w_srcB)
  );

  // Advance the in-flight slots and latch forward selects with ID/EX
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exSlot <= '0;
      r_memRd  <= '0;
      r_memWe  <= 1'b0;
      r_fa     <= 1'b0;
      r_fb     <= 1'b0;
      r_srcA   <= 1'b0;
      r_srcB   <= 1'b0;
    end else begin
      r_memRd <= r_exSlot.rd;
      r_memWe <= r_exSlot.we;
      if (w_bubble) begin
        r_exSlot <= '0;
        r_fa     <= 1'b0;
        r_fb     <= 1'b0;
        r_srcA   <= 1'b0;
        r_srcB   <= 1'b0;
      end else begin
        r_exSlot.rd   <= hazBus.rdId;
        r_exSlot.we   <= hazBus.regWriteId && (hazBus.rdId != '0);
        r_exSlot.load <= hazBus.memReadId;
        r_fa          <= w_fwdA;
        r_fb          <= w_fwdB;
        r_srcA        <= w_srcA;
        r_srcB        <= w_srcB;
      end
    end
  end

  assign hazBus.stall   = w_stall;
  assign hazBus.bubbleE = w_bubble;
  assign hazBus.Fa      = r_fa;
  assign hazBus.Fb      = r_fb;
  assign hazBus.fwdSrcA = r_srcA;
  assign hazBus.fwdSrcB = r_srcB;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stallCount;
  logic [31:0] r_flushCount;

  // Count stall and flush cycles; both simply wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      r_stallCount <= r_stallCount + {31'd0, w_stall};
      r_flushCount <= r_flushCount + {31'd0, hazBus.flush};
    end
  end

  assign hazBus.stallCount = r_stallCount;
  assign hazBus.flushCount = r_flushCount;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: each issued ID vector pushes
// its hand-computed expectation; a monitor pops and compares the
// combinational controls mid-cycle and the registered selects after the edge.
module tb_hazard_forward_unit;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } expItem_t;

  logic clk = 1'b1;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  expItem_t expQ[$];

  hazard_forward_unit_if hazBus();

  hazard_forward_unit u_dut (
    .clk    (clk),
    .rst    (rst),
    .hazBus (hazBus)
  );

  // Free-running clock; negedge comes first so the monitor lines up
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // exp = {stall, bubbleE, Fa, Fb, fwdSrcA, fwdSrcB}
  task automatic applyStimulus(input string tag, input logic v,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic we,
                               input logic ld, input logic fl,
                               input logic rs, input logic [5:0] exp);
    expItem_t item;
    hazBus.idValid    = v;
    hazBus.rs1Id      = rs1;
    hazBus.rs2Id      = rs2;
    hazBus.useRs1     = u1;
    hazBus.useRs2     = u2;
    hazBus.rdId       = rd;
    hazBus.regWriteId = we;
    hazBus.memReadId  = ld;
    hazBus.flush      = fl;
    rst               = rs;
    item.tag = tag;
    item.exp = exp;
    expQ.push_back(item);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus("idle", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0,
                  1'b0, 1'b0, 6'b010000);
  endtask

  // Monitor: comb controls at negedge, registered selects after the edge
  initial begin
    expItem_t cur;
    logic gotStall, gotBub;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        cur      = expQ.pop_front();
        gotStall = hazBus.stall;
        gotBub   = hazBus.bubbleE;
        @(posedge clk);
        #2;
        checkOutput({cur.tag, ".stall"},   {31'd0, gotStall},       {31'd0, cur.exp[5]});
        checkOutput({cur.tag, ".bubbleE"}, {31'd0, gotBub},         {31'd0, cur.exp[4]});
        checkOutput({cur.tag, ".Fa"},      {31'd0, hazBus.Fa},      {31'd0, cur.exp[3]});
        checkOutput({cur.tag, ".Fb"},      {31'd0, hazBus.Fb},      {31'd0, cur.exp[2]});
        checkOutput({cur.tag, ".fwdSrcA"}, {31'd0, hazBus.fwdSrcA}, {31'd0, cur.exp[1]});
        checkOutput({cur.tag, ".fwdSrcB"}, {31'd0, hazBus.fwdSrcB}, {31'd0, cur.exp[0]});
      end
    end
  end

  // Directed instruction stream
  initial begin
    applyStimulus("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b010000);
    applyStimulus("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b010000);
    idle();

    // ALU chain: add x5 ; sub x6,x5,x1 ; operands read but unused
    applyStimulus("alu_add",   1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 6'b000000);
    applyStimulus("alu_sub",   1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 6'b001000);
    applyStimulus("alu_nouse", 1, 6, 5, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
    idle();

    // Distance 2: add x5 ; nop ; or x7,x2,x5
    applyStimulus("d2_add", 1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 6'b000000);
    idle();
    applyStimulus("d2_or",  1, 2, 5, 1, 1, 7, 1, 0, 0, 0, 6'b000101);
    idle();
    idle();

    // Load-use: lw x8 ; add x9,x8,x8 (held one cycle)
    applyStimulus("lu_lw",    1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 6'b000000);
    applyStimulus("lu_stall", 1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 6'b110000);
    applyStimulus("lu_issue", 1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 6'b001111);
    idle();
    idle();

    // Double producer: add x5 ; add x5 ; use x5 on both operands
    applyStimulus("dp_add1", 1, 1, 2, 1, 1, 5,  1, 0, 0, 0, 6'b000000);
    applyStimulus("dp_add2", 1, 1, 2, 1, 1, 5,  1, 0, 0, 0, 6'b000000);
    applyStimulus("dp_use",  1, 5, 5, 1, 1, 10, 1, 0, 0, 0, 6'b001100);
    idle();
    idle();

    // Flush beats stall; flushed x11 writer never becomes a producer
    applyStimulus("fl_lw",   1, 1,  0, 1, 0, 8,  1, 1, 0, 0, 6'b000000);
    applyStimulus("fl_cons", 1, 8,  8, 1, 1, 11, 1, 0, 1, 0, 6'b010000);
    applyStimulus("fl_next", 1, 11, 8, 1, 1, 12, 1, 0, 0, 0, 6'b000101);
    idle();
    idle();

    // x0 is never a producer, even for a load
    applyStimulus("x0_prod", 1, 1, 0,  1, 0, 0,  1, 0, 0, 0, 6'b000000);
    applyStimulus("x0_cons", 1, 0, 0,  1, 1, 13, 1, 0, 0, 0, 6'b000000);
    applyStimulus("x0_lw",   1, 1, 0,  1, 0, 0,  1, 1, 0, 0, 6'b000000);
    applyStimulus("x0_use",  1, 0, 13, 1, 1, 14, 1, 0, 0, 0, 6'b000101);
    idle();
    idle();

`ifdef HAZARD_PERF_EN
    checkOutput("perf.stallCountPre", hazBus.stallCount, 32'd1);
    checkOutput("perf.flushCountPre", hazBus.flushCount, 32'd1);
`endif

    // Reset mid-stall (rs2-only dependency): slots cleared by the rst edge
    applyStimulus("rs_lw",       1, 1, 0, 1, 0, 8,  1, 1, 0, 0, 6'b000000);
    applyStimulus("rs_stallrst", 1, 3, 8, 0, 1, 15, 1, 0, 0, 1, 6'b110000);
`ifdef HAZARD_PERF_EN
    checkOutput("perf.stallCountRst", hazBus.stallCount, 32'd0);
    checkOutput("perf.flushCountRst", hazBus.flushCount, 32'd0);
`endif
    applyStimulus("rs_after",    1, 3, 8, 0, 1, 15, 1, 0, 0, 0, 6'b000000);
    idle();

    // Single load-use after reset
    applyStimulus("pc_lw",    1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 6'b000000);
    applyStimulus("pc_stall", 1, 8, 0, 1, 0, 9, 1, 0, 0, 0, 6'b110000);
    applyStimulus("pc_issue", 1, 8, 0, 1, 0, 9, 1, 0, 0, 0, 6'b001010);
`ifdef HAZARD_PERF_EN
    checkOutput("perf.stallCountOne", hazBus.stallCount, 32'd1);
`endif
    idle();

    repeat (3) @(posedge clk);
    #3;
    checkOutput("scoreboard.drained", expQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Sits in ID. Tracks destination registers of instructions in flight.
- Produces the registered per-operand forward selects (Fa/Fb plus source) that the EX operand muxes consume, in step with the ID/EX register.
- Generates the load-use stall and inserts bubbles on stall or branch flush.

Parameters:
- REG_ADDR_W, 5, register-address width; register 0 is hard-wired zero and never forwarded.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- idValid  in  1  ID holds a real instruction
- rs1Id  in  REG_ADDR_W  ID source register 1
- rs2Id  in  REG_ADDR_W  ID source register 2
- useRs1  in  1  ID instruction reads rs1
- useRs2  in  1  ID instruction reads rs2
- rdId  in  REG_ADDR_W  ID destination register
- regWriteId  in  1  ID instruction writes rd
- memReadId  in  1  ID instruction is a load
- flush  in  1  branch taken, resolved in EX this cycle
- stall  out  1  hold PC and IF/ID (combinational)
- bubbleE  out  1  ID/EX must load a NOP next edge (combinational)
- Fa  out  1  EX operand 1 takes forwarded value (registered)
- Fb  out  1  EX operand 2 takes forwarded value (registered)
- fwdSrcA  out  1  0 = AluOut (EX/MEM), 1 = Result (WB); valid when Fa (registered)
- fwdSrcB  out  1  same for operand 2

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Internal slots: EX slot {exRd, exWe, exLoad} and MEM slot {memRd, memWe}; both describe the instruction currently in that stage.
- Reset values: all slot fields 0; Fa, Fb, fwdSrcA, fwdSrcB = 0; stall = 0 once rst is sampled.
- stall = idValid & !flush & exLoad & exWe & exRd!=0 & ((useRs1 & rs1Id==exRd) | (useRs2 & rs2Id==exRd)).
- bubbleE = stall | flush | !idValid.
- Each edge, MEM slot <= EX slot.
  - If bubbleE: EX slot <= 0, and Fa/Fb/fwdSrc <= 0.
  - Else: EX slot <= {rdId, regWriteId & rdId!=0, memReadId}, and forward selects are loaded as below.
- Forward decision for rs1 (rs2 identical, driving Fb/fwdSrcB), evaluated in ID:
  - If useRs1 & exWe & exRd==rs1Id & rs1Id!=0: Fa=1, fwdSrcA=0. Producer will be in MEM next cycle.
  - Else if useRs1 & memWe & memRd==rs1Id & rs1Id!=0: Fa=1, fwdSrcA=1. Producer will be in WB.
  - Else Fa=0.
  - The younger producer always wins.
- Load-use timing:
  - Load in EX while the consumer is in ID gives exactly 1 stall cycle.
  - Next cycle the load is in MEM; the consumer is issued with Fa/Fb=1 and fwdSrc=1.
- WB-to-ID hazards are covered by register-file write-through and are not tracked.
- flush has priority over stall. A flushed ID instruction never stalls and never becomes a producer.
- rst asserted mid-stall: next edge clears all slots; stall deasserts because exLoad=0.
- A producer with rd=0 never matches.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds outputs stallCount[31:0] and flushCount[31:0].
  - Each increments on every edge with stall=1 (resp. flush=1).
  - Both wrap at 2^32 and reset to 0.
- When undefined, the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds:
  - typedef for a hazard slot struct {rd, we, load};
  - REG_ADDR_W default;
  - localparams FWD_SRC_ALU=0 and FWD_SRC_RESULT=1.
- Natural sub-module: hazard_fwd_select, a combinational per-operand match/priority block instantiated twice (operand A, operand B).

Test Plan:
- ALU chain: add x5 then sub x6,x5,x1 back-to-back -> at sub's EX cycle Fa=1, fwdSrcA=0, Fb=0, stall never 1.
- Distance 2: add x5, nop, or x7,x2,x5 -> Fb=1, fwdSrcB=1, Fa=0.
- Load-use: lw x8 then add x9,x8,x8 -> stall=1 and bubbleE=1 for exactly 1 cycle; then Fa=Fb=1, fwdSrcA=fwdSrcB=1.
- Double producer: add x5; add x5; use x5 -> Fa=1, fwdSrcA=0 (younger wins).
- Flush priority: lw x8 in EX, consumer of x8 in ID, flush=1 the same cycle -> stall=0, next cycle Fa=Fb=0 and EX slot empty.
- x0 and reset:
  - Producer rd=0 followed by a consumer of x0 -> Fa=Fb=0.
  - rst pulse during a load-use stall -> next cycle stall=0 and all outputs 0.
  - With HAZARD_PERF_EN, stallCount=0 after rst and equals 1 after a single load-use.
